// File: rtl/usb3_slfifo_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : usb3_slfifo_reader_if
// Brief    : FX3 slave-FIFO read pins plus the word stream toward the RAM cache.
// Revision : 1.0
// ============================================================================
interface usb3_slfifo_reader_if;
    logic        rd_en;
    logic        USB3_FLAGA;
    logic [31:0] USB3_DQ;
    logic        USB3_SLCS_n;
    logic        USB3_SLOE_n;
    logic        USB3_SLRD_n;
    logic [1:0]  USB3_A;
    logic [31:0] data;
    logic [3:0]  usb_rd_state;
    logic [15:0] burst_count;
    logic        rd_busy;

    modport master (
        input  rd_en, USB3_FLAGA, USB3_DQ,
        output USB3_SLCS_n, USB3_SLOE_n, USB3_SLRD_n, USB3_A,
               data, usb_rd_state, burst_count, rd_busy
    );

    modport slave (
        output rd_en, USB3_FLAGA, USB3_DQ,
        input  USB3_SLCS_n, USB3_SLOE_n, USB3_SLRD_n, USB3_A,
               data, usb_rd_state, burst_count, rd_busy
    );
endinterface
`default_nettype wire

// File: rtl/usb3_slfifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : usb3_slfifo_reader
// Brief    : Slave-FIFO read master pulling fixed bursts from the FX3 into a
//            registered 32-bit word stream with a phase code for the cache.
// Revision : 1.0
// ============================================================================
module usb3_slfifo_reader #(
    parameter int         BURST_LEN = 256,
    parameter logic [1:0] FIFO_ADDR = 2'b00
) (
    input  logic                 wrclock,
    input  logic                 rst,
    usb3_slfifo_reader_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WAIT_FLAG = 4'd1,
        S_SELECT    = 4'd2,
        S_FILL0     = 4'd3,
        S_FILL1     = 4'd4,
        S_FILL2     = 4'd5,
        S_DATA      = 4'd6,
        S_GAP       = 4'd7
    } state_t;

    localparam logic [8:0] c_burst_len = 9'(BURST_LEN);
    localparam logic [8:0] c_data_last = 9'(BURST_LEN - 1);
    localparam logic [8:0] c_gap_last  = 9'd2;

    state_t      r_state;
    state_t      w_next_state;
    logic [8:0]  r_rd_cnt;
    logic [8:0]  w_rd_cnt_next;
    logic [8:0]  r_dwell;
    logic        w_in_burst;
    logic        w_rd_next;
    logic        w_busy_next;
    logic        r_slcs_n;
    logic        r_sloe_n;
    logic        r_slrd_n;
    logic        r_rd_busy;
    logic [1:0]  r_addr;
    logic [31:0] r_data;
    logic [15:0] r_burst_count;

    // Next state plus the next values of every registered strobe, so the pins
    // change on the same edge as the state they belong to.
    always_comb begin
        w_next_state  = r_state;
        w_rd_cnt_next = r_rd_cnt + {8'd0, ~r_slrd_n};
        w_in_burst    = 1'b0;
        w_rd_next     = 1'b0;
        w_busy_next   = 1'b0;

        case (r_state)
            S_IDLE:      if (bus.rd_en) w_next_state = S_WAIT_FLAG;
            S_WAIT_FLAG: begin
                if (!bus.rd_en)          w_next_state = S_IDLE;
                else if (bus.USB3_FLAGA) w_next_state = S_SELECT;
            end
            S_SELECT:    w_next_state = S_FILL0;
            S_FILL0:     w_next_state = S_FILL1;
            S_FILL1:     w_next_state = S_FILL2;
            S_FILL2:     w_next_state = S_DATA;
            S_DATA:      if (r_dwell == c_data_last) w_next_state = S_GAP;
            S_GAP: begin
                if (r_dwell == c_gap_last)
                    w_next_state = bus.rd_en ? S_WAIT_FLAG : S_IDLE;
            end
            default:     w_next_state = S_IDLE;
        endcase

        w_in_burst  = (w_next_state >= S_SELECT) && (w_next_state <= S_DATA);
        // The FX3 returns data two cycles late, so the read strobe stops once
        // BURST_LEN reads are issued, while the data phase keeps draining.
        w_rd_next   = (w_next_state >= S_FILL0) && (w_next_state <= S_DATA)
                      && (w_rd_cnt_next < c_burst_len);
        w_busy_next = (w_next_state != S_IDLE) && (w_next_state != S_WAIT_FLAG);
    end

    always_ff @(posedge wrclock) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_rd_cnt      <= 9'd0;
            r_dwell       <= 9'd0;
            r_slcs_n      <= 1'b1;
            r_sloe_n      <= 1'b1;
            r_slrd_n      <= 1'b1;
            r_rd_busy     <= 1'b0;
            r_addr        <= FIFO_ADDR;
            r_data        <= 32'd0;
            r_burst_count <= 16'd0;
        end else begin
            r_state   <= w_next_state;
            r_dwell   <= (w_next_state == r_state) ? r_dwell + 9'd1 : 9'd0;
            r_rd_cnt  <= ((r_state >= S_FILL0) && (r_state <= S_DATA)) ? w_rd_cnt_next : 9'd0;
            r_slcs_n  <= ~w_in_burst;
            r_sloe_n  <= ~w_in_burst;
            r_slrd_n  <= ~w_rd_next;
            r_rd_busy <= w_busy_next;
            r_addr    <= FIFO_ADDR;
            if (w_next_state == S_DATA)
                r_data <= bus.USB3_DQ;
            if ((w_next_state == S_GAP) && (r_state != S_GAP))
                r_burst_count <= r_burst_count + 16'd1;
        end
    end

    assign bus.USB3_SLCS_n  = r_slcs_n;
    assign bus.USB3_SLOE_n  = r_sloe_n;
    assign bus.USB3_SLRD_n  = r_slrd_n;
    assign bus.USB3_A       = r_addr;
    assign bus.data         = r_data;
    assign bus.usb_rd_state = r_state;
    assign bus.burst_count  = r_burst_count;
    assign bus.rd_busy      = r_rd_busy;

endmodule
`default_nettype wire

// File: tb/tb_usb3_slfifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb3_slfifo_reader
// Brief    : FX3 read-side model with an expected-word queue for the reader.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_usb3_slfifo_reader;

    localparam int BURST_LEN = 256;
    localparam int PERIOD    = 1 + 1 + 3 + BURST_LEN + 3;

    logic wrclock = 1'b0;
    logic rst;

    usb3_slfifo_reader_if bus_if();

    usb3_slfifo_reader #(
        .BURST_LEN (BURST_LEN),
        .FIFO_ADDR (2'b00)
    ) dut (
        .wrclock (wrclock),
        .rst     (rst),
        .bus     (bus_if)
    );

    always #5 wrclock = ~wrclock;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge wrclock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // FX3 model: a read sampled low returns word k two edges later; the
    // expected word is queued at the moment the read is issued.
    logic [31:0] exp_q[$];
    logic [31:0] fx3_stage = 32'hDEAD_BEEF;
    int          fx3_ptr   = 0;
    always @(posedge wrclock) begin
        bus_if.USB3_DQ <= fx3_stage;
        if (!bus_if.USB3_SLCS_n && !bus_if.USB3_SLRD_n) begin
            fx3_stage <= 32'(fx3_ptr);
            exp_q.push_back(32'(fx3_ptr));
            fx3_ptr   <= fx3_ptr + 1;
        end else begin
            fx3_stage <= 32'hDEAD_BEEF;
            if (bus_if.USB3_SLCS_n) begin
                fx3_ptr <= 0;
                exp_q.delete();
            end
        end
    end

    // Monitor: pops one expected word per data-valid cycle, measures run
    // lengths, inter-burst gaps, burst start cycles and read-strobe count.
    int run6     = 0;
    int last_run = 0;
    int gap      = 0;
    int starts   = 0;
    int slrd_low = 0;
    int start_cyc[$];
    always @(negedge wrclock) begin
        logic [31:0] exp_w;
        if (bus_if.usb_rd_state == 4'd6) begin
            if (run6 == 0) begin
                if (starts > 0) check("gap_ge_3", 32'(gap >= 3), 32'd1);
                starts++;
                start_cyc.push_back(cyc);
            end
            run6++;
            if (exp_q.size() != 0) exp_w = exp_q.pop_front();
            else                   exp_w = 'x;
            check("word", bus_if.data, exp_w);
        end else begin
            if (run6 != 0) begin
                last_run = run6;
                run6     = 0;
                gap      = 0;
            end
            gap++;
        end
        if (!bus_if.USB3_SLRD_n) slrd_low++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge wrclock);
            #1;
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
        int i = 0;
        while (bus_if.usb_rd_state !== s && i < budget) begin
            step(1);
            i++;
        end
        check(tag, 32'(bus_if.usb_rd_state), 32'(s));
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int slrd0;
        int s0;
        int ci;

        rst = 1'b1;
        bus_if.rd_en      = 1'b1;
        bus_if.USB3_FLAGA = 1'b1;
        step(2);
        check("rst_strobes", {29'd0, bus_if.USB3_SLCS_n, bus_if.USB3_SLOE_n, bus_if.USB3_SLRD_n}, 32'd7);
        check("rst_state",   32'(bus_if.usb_rd_state), 32'd0);
        check("rst_bcount",  32'(bus_if.burst_count), 32'd0);
        check("rst_busy",    32'(bus_if.rd_busy), 32'd0);
        check("rst_data",    bus_if.data, 32'd0);
        check("rst_addr",    32'(bus_if.USB3_A), 32'd0);

        // Single burst: states 0,1,2 follow reset release, read strobe in the fourth cycle
        slrd0 = slrd_low;
        rst   = 1'b0;
        n = 0;
        while (bus_if.USB3_SLRD_n === 1'b1 && n < 10) begin
            step(1);
            n++;
        end
        check("first_slrd_delay", 32'(n), 32'd3);
        bus_if.USB3_FLAGA = 1'b0;
        wait_state(4'd7, 400, "single_reach_gap");
        wait_state(4'd1, 10, "single_back_wait");
        check("single_run_len", 32'(last_run), 32'(BURST_LEN));
        check("single_slrd_cnt", 32'(slrd_low - slrd0), 32'(BURST_LEN));
        check("single_bcount", 32'(bus_if.burst_count), 32'd1);
        check("data_holds", bus_if.data, 32'(BURST_LEN - 1));
        check("idle_busy", 32'(bus_if.rd_busy), 32'd0);

        // Flag low: the reader parks in WAIT_FLAG without selecting the FX3
        for (int i = 0; i < 50; i++) begin
            step(1);
            check("flag_gate", {27'd0, bus_if.usb_rd_state, bus_if.USB3_SLCS_n}, {27'd0, 4'd1, 1'b1});
        end
        bus_if.rd_en = 1'b0;
        step(1);
        check("en_drop_idle", 32'(bus_if.usb_rd_state), 32'd0);

        // Back-to-back bursts at the minimum period
        s0    = starts;
        ci    = start_cyc.size();
        slrd0 = slrd_low;
        bus_if.rd_en      = 1'b1;
        bus_if.USB3_FLAGA = 1'b1;
        n = 0;
        while (starts < s0 + 4 && n < 4 * PERIOD + 50) begin
            step(1);
            n++;
        end
        check("b2b_starts", 32'(starts - s0), 32'd4);
        bus_if.USB3_FLAGA = 1'b0;
        wait_state(4'd7, 400, "b2b_reach_gap");
        wait_state(4'd1, 10, "b2b_back_wait");
        if (start_cyc.size() >= ci + 4) begin
            for (int i = 1; i < 4; i++)
                check("b2b_period", 32'(start_cyc[ci + i] - start_cyc[ci + i - 1]), 32'(PERIOD));
        end
        check("b2b_run_len", 32'(last_run), 32'(BURST_LEN));
        check("b2b_slrd_cnt", 32'(slrd_low - slrd0), 32'(4 * BURST_LEN));
        check("b2b_bcount", 32'(bus_if.burst_count), 32'd5);

        // Enable dropped mid-burst: burst completes, three gap cycles, then IDLE
        bus_if.USB3_FLAGA = 1'b1;
        wait_state(4'd6, 20, "en_mid_reach_data");
        bus_if.rd_en = 1'b0;
        wait_state(4'd7, 300, "en_mid_reach_gap");
        step(3);
        check("en_mid_idle", 32'(bus_if.usb_rd_state), 32'd0);
        check("en_mid_run_len", 32'(last_run), 32'(BURST_LEN));
        check("en_mid_bcount", 32'(bus_if.burst_count), 32'd6);
        step(5);
        check("en_mid_stay_idle", 32'(bus_if.usb_rd_state), 32'd0);

        // Reset at word 100 discards the burst; the next one is complete
        bus_if.rd_en = 1'b1;
        n = 0;
        while (run6 < 101 && n < 400) begin
            step(1);
            n++;
        end
        check("rst_mid_word100", 32'(run6), 32'd101);
        rst = 1'b1;
        step(1);
        check("rst_mid_strobes", {29'd0, bus_if.USB3_SLCS_n, bus_if.USB3_SLOE_n, bus_if.USB3_SLRD_n}, 32'd7);
        check("rst_mid_state", 32'(bus_if.usb_rd_state), 32'd0);
        check("rst_mid_bcount", 32'(bus_if.burst_count), 32'd0);
        rst   = 1'b0;
        slrd0 = slrd_low;
        wait_state(4'd6, 20, "rst_mid_next_data");
        bus_if.USB3_FLAGA = 1'b0;
        wait_state(4'd7, 300, "rst_mid_reach_gap");
        wait_state(4'd1, 10, "rst_mid_back_wait");
        check("rst_mid_run_len", 32'(last_run), 32'(BURST_LEN));
        check("rst_mid_slrd_cnt", 32'(slrd_low - slrd0), 32'(BURST_LEN));
        check("rst_mid_bcount1", 32'(bus_if.burst_count), 32'd1);

        // Counter wrap from 0xFFFF
        force dut.r_burst_count = 16'hFFFF;
        step(2);
        release dut.r_burst_count;
        step(1);
        check("wrap_preload", 32'(bus_if.burst_count), 32'h0000_FFFF);
        bus_if.USB3_FLAGA = 1'b1;
        wait_state(4'd6, 20, "wrap_reach_data");
        bus_if.USB3_FLAGA = 1'b0;
        wait_state(4'd7, 300, "wrap_reach_gap");
        check("wrap_bcount", 32'(bus_if.burst_count), 32'd0);
        wait_state(4'd1, 10, "wrap_back_wait");
        check("wrap_run_len", 32'(last_run), 32'(BURST_LEN));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
